// File: rtl/avalon_mem_pkg.sv
// Shared types and helpers for the banked Avalon-MM memory model.
package avalon_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [31:0] UNMAPPED_DATA = 32'hDEADBEEF;

  // Lane i comes from new_word when be[i] is set, otherwise from old_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/avalon_mem_banked_if.sv
// Avalon-MM slave bus with error side-band flags, seen from both ends.
interface avalon_mem_banked_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        err_unmapped;
  logic        err_misalign;
  logic        err_protocol;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, err_unmapped, err_misalign, err_protocol
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, err_unmapped, err_misalign, err_protocol
  );
endinterface

// File: rtl/avalon_region_decode.sv
// Combinational address decoder: byte address -> region hit and index into the flat word array.
module avalon_region_decode #(
  parameter int                             NUM_REGIONS  = 4,
  parameter logic [NUM_REGIONS-1:0][31:0]   REGION_BASE  = {32'h0000_0000, 32'hBFC0_0000,
                                                            32'hBFBE_0000, 32'hB400_0000},
  parameter logic [NUM_REGIONS-1:0][31:0]   REGION_WORDS = {32'd1024, 32'd1024, 32'd16, 32'd16},
  parameter int                             IDX_W        = 12
) (
  input  logic [31:0]      address_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] flat_index_o
);

  // Words occupied by all regions below idx in the flat array.
  function automatic logic [31:0] region_offset(input int idx);
    logic [31:0] sum;
    sum = '0;
    for (int k = 0; k < idx; k++) sum = sum + REGION_WORDS[k];
    return sum;
  endfunction

  logic [NUM_REGIONS-1:0] hit_vec;
  logic [IDX_W-1:0]       idx_vec [NUM_REGIONS];

  for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
    // 34-bit bounds so a window ending at the top of the address space cannot wrap
    localparam logic [33:0] LO     = {2'b00, REGION_BASE[gi]};
    localparam logic [33:0] HI     = LO + {REGION_WORDS[gi], 2'b00};
    localparam logic [31:0] OFFSET = region_offset(gi);

    assign hit_vec[gi] = ({2'b00, address_i} >= LO) && ({2'b00, address_i} < HI);
    assign idx_vec[gi] = IDX_W'(OFFSET + ((address_i - REGION_BASE[gi]) >> 2));
  end

  // Scan downwards so the lowest-numbered overlapping region wins.
  always_comb begin
    hit_o        = 1'b0;
    flat_index_o = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_o        = 1'b1;
        flat_index_o = idx_vec[i];
      end
    end
  end

endmodule

// File: rtl/avalon_mem_banked.sv
// Clocked Avalon-MM slave memory: region-mapped flat word array, wait states with optional
// LFSR stalls, byte-lane masking and unmapped/misaligned/protocol error pulses.
module avalon_mem_banked
  import avalon_mem_pkg::*;
#(
  parameter int                           NUM_REGIONS  = 4,
  parameter logic [NUM_REGIONS-1:0][31:0] REGION_BASE  = {32'h0000_0000, 32'hBFC0_0000,
                                                          32'hBFBE_0000, 32'hB400_0000},
  parameter logic [NUM_REGIONS-1:0][31:0] REGION_WORDS = {32'd1024, 32'd1024, 32'd16, 32'd16},
  parameter int                           WAIT_CYCLES  = 2,
  parameter bit                           STALL_MODE   = 1'b0,
  parameter int                           MAX_STALL    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  avalon_mem_banked_if.slave bus
);

  function automatic int total_words();
    int s;
    s = 0;
    for (int k = 0; k < NUM_REGIONS; k++) s = s + int'(REGION_WORDS[k]);
    return s;
  endfunction

  localparam int TOTAL_WORDS = total_words();
  localparam int IDX_W       = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
  localparam int STALL_W     = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;

  state_t             state_q;
  logic [3:0]         cnt_q;
  logic [STALL_W-1:0] stalls_q;
  logic [15:0]        lfsr_q;
  logic [31:0]        addr_q, wdata_q, readdata_q, old_q;
  logic [3:0]         be_q;
  logic               rd_q, wr_q, proto_q, waitreq_q;
  logic               err_unm_q, err_mis_q, err_pro_q;
  logic [31:0]        mem_q [TOTAL_WORDS];

  // Live bus while idle, latched request once the access is in flight.
  logic [31:0]      acc_addr;
  logic [3:0]       acc_be;
  logic             acc_rd, acc_wr;
  logic             hit;
  logic [IDX_W-1:0] flat_idx;

  assign acc_addr = (state_q == IDLE) ? bus.address    : addr_q;
  assign acc_be   = (state_q == IDLE) ? bus.byteenable : be_q;
  assign acc_rd   = (state_q == IDLE) ? bus.read       : rd_q;
  assign acc_wr   = (state_q == IDLE) ? bus.write      : wr_q;

  avalon_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_WORDS(REGION_WORDS),
    .IDX_W       (IDX_W)
  ) u_decode (
    .address_i   (acc_addr),
    .hit_o       (hit),
    .flat_index_o(flat_idx)
  );

  logic req_changed, stall, enter_ack;

  assign req_changed = (bus.address != addr_q) || (bus.read != rd_q) || (bus.write != wr_q) ||
                       (wr_q && (bus.writedata != wdata_q));
  assign stall       = STALL_MODE && lfsr_q[0] && (stalls_q < STALL_W'(MAX_STALL));
  assign enter_ack   = ((state_q == IDLE) && (bus.read || bus.write) && (WAIT_CYCLES == 0)) ||
                       ((state_q == WAIT) && (cnt_q <= 4'd1) && !stall);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      stalls_q   <= '0;
      lfsr_q     <= LFSR_SEED;
      proto_q    <= 1'b0;
      waitreq_q  <= 1'b1;
      readdata_q <= '0;
      err_unm_q  <= 1'b0;
      err_mis_q  <= 1'b0;
      err_pro_q  <= 1'b0;
    end else begin
      lfsr_q    <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      waitreq_q <= 1'b1;
      err_unm_q <= 1'b0;
      err_mis_q <= 1'b0;
      err_pro_q <= 1'b0;

      if (enter_ack) begin
        waitreq_q <= 1'b0;
        err_unm_q <= !hit;
        err_mis_q <= (acc_addr[1:0] != 2'b00);
        err_pro_q <= (acc_rd && acc_wr) || proto_q || ((state_q == WAIT) && req_changed);
        if (acc_rd && acc_wr) readdata_q <= '0;
        else if (acc_rd)      readdata_q <= hit ? byte_merge(32'h0, mem_q[flat_idx], acc_be)
                                                : UNMAPPED_DATA;
      end

      case (state_q)
        IDLE: if (bus.read || bus.write) begin
          addr_q   <= bus.address;
          wdata_q  <= bus.writedata;
          be_q     <= bus.byteenable;
          rd_q     <= bus.read;
          wr_q     <= bus.write;
          cnt_q    <= 4'(WAIT_CYCLES);
          stalls_q <= '0;
          proto_q  <= 1'b0;
          state_q  <= (WAIT_CYCLES == 0) ? ACK : WAIT;
        end
        WAIT: begin
          if (req_changed) proto_q <= 1'b1;
          if (cnt_q > 4'd1) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            cnt_q <= '0;
            if (stall) stalls_q <= stalls_q + STALL_W'(1);
            else       state_q  <= ACK;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Registered read port feeds the read-modify-write; in ACK old_q holds the target word.
  always_ff @(posedge clk) begin
    old_q <= mem_q[flat_idx];
    if (reset_n && (state_q == ACK) && wr_q && !rd_q && hit)
      mem_q[flat_idx] <= byte_merge(old_q, wdata_q, be_q);
  end

  assign bus.waitrequest  = waitreq_q;
  assign bus.readdata     = readdata_q;
  assign bus.err_unmapped = err_unm_q;
  assign bus.err_misalign = err_mis_q;
  assign bus.err_protocol = err_pro_q;

endmodule

// File: tb/tb_avalon_mem_banked.sv
// Self-checking bench: directed scenarios on a fixed-latency instance, randomized traffic
// on a stalling instance, all checked against an address-keyed reference model.
module tb_avalon_mem_banked;

  localparam int MAX_STALL = 8;
  localparam logic [31:0] BASES [4] = '{32'hB400_0000, 32'hBFBE_0000, 32'hBFC0_0000, 32'h0000_0000};
  localparam int          WORDS [4] = '{16, 16, 1024, 1024};

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  avalon_mem_banked_if bus_f();
  avalon_mem_banked_if bus_r();

  avalon_mem_banked #(.WAIT_CYCLES(2), .STALL_MODE(1'b0), .MAX_STALL(MAX_STALL)) dut_fixed (
    .clk(clk), .reset_n(reset_n), .bus(bus_f)
  );
  avalon_mem_banked #(.WAIT_CYCLES(2), .STALL_MODE(1'b1), .MAX_STALL(MAX_STALL)) dut_rand (
    .clk(clk), .reset_n(reset_n), .bus(bus_r)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int txn_no   = 0;
  bit sel      = 1'b0;

  logic        s_wait;
  logic [31:0] s_rdata;
  logic [2:0]  s_err;
  always_comb begin
    if (sel) begin
      s_wait  = bus_r.waitrequest;
      s_rdata = bus_r.readdata;
      s_err   = {bus_r.err_unmapped, bus_r.err_misalign, bus_r.err_protocol};
    end else begin
      s_wait  = bus_f.waitrequest;
      s_rdata = bus_f.readdata;
      s_err   = {bus_f.err_unmapped, bus_f.err_misalign, bus_f.err_protocol};
    end
  end

  // Reference memory keyed by {instance, word-aligned byte address}.
  logic [31:0] model [logic [32:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic bit is_mapped(input logic [31:0] a);
    for (int i = 0; i < 4; i++) begin
      if ({32'h0, a} >= {32'h0, BASES[i]} &&
          {32'h0, a} <  {32'h0, BASES[i]} + 64'(4 * WORDS[i])) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] w, input logic [3:0] be);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  task automatic set_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
    if (sel) begin
      bus_r.read = rd; bus_r.write = wr; bus_r.address = a; bus_r.writedata = wd; bus_r.byteenable = be;
    end else begin
      bus_f.read = rd; bus_f.write = wr; bus_f.address = a; bus_f.writedata = wd; bus_f.byteenable = be;
    end
  endtask

  // Holds the request until waitrequest drops; counts high cycles and errors seen outside ACK.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output int hi, output logic [31:0] rdata,
                        output logic [2:0] errs, output logic [2:0] stray);
    bit done;
    hi = 0; rdata = '0; errs = '0; stray = '0; done = 1'b0;
    @(posedge clk); #1;
    set_req(rd, wr, a, wd, be);
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (s_wait) begin
        hi++;
        stray |= s_err;
      end else begin
        rdata = s_rdata;
        errs  = s_err;
        done  = 1'b1;
      end
    end
    if (!done) chk("ack_timeout", 32'(done), 32'd1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    stray |= s_err;
  endtask

  task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rdata);
    int          hi;
    logic [2:0]  errs, stray, exp_e;
    logic [31:0] word, exp_r;
    logic [32:0] key;
    bit          mapped;
    mapped = is_mapped(a);
    key    = {sel, a[31:2], 2'b00};
    word   = model.exists(key) ? model[key] : 32'h0;
    access(rd, wr, a, wd, be, hi, rdata, errs, stray);
    txn_no++;
    $display("txn %0d dut=%0d rd=%0b wr=%0b addr=%h wd=%h be=%b rdata=%h hi=%0d err=%b",
             txn_no, sel, rd, wr, a, wd, be, rdata, hi, errs);
    if (sel) chk("lat_range", 32'(hi >= 3 && hi <= 3 + MAX_STALL), 32'd1);
    else     chk("lat", 32'(hi), 32'd3);
    exp_e = {!mapped, a[1:0] != 2'b00, rd && wr};
    chk("err", 32'(errs), 32'(exp_e));
    chk("stray_err", 32'(stray), 32'd0);
    if (rd) begin
      exp_r = wr ? 32'h0 : (mapped ? lanes(word, be) : 32'hDEADBEEF);
      chk("rdata", rdata, exp_r);
    end
    if (wr && !rd && mapped) begin
      for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wd[8*i +: 8];
      model[key] = word;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd_v;
    reset_n = 1'b0;
    sel = 1'b0;
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sel = 1'b1;
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sel = 1'b0;
    set_req(1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'hF);

    // Reset held for two edges with a read pending: no completion, outputs at reset values.
    for (int e = 0; e < 2; e++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_wait", 32'(s_wait), 32'd1);
      chk("rst_rdata", s_rdata, 32'h0);
      chk("rst_err", 32'(s_err), 32'd0);
    end
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    reset_n = 1'b1;

    // Byte-lane write masking and read-back.
    txn(1'b0, 1'b1, 32'hBFC0_0004, 32'hAABB_CCDD, 4'hF, rd_v);
    txn(1'b0, 1'b1, 32'hBFC0_0004, 32'h1122_3344, 4'b0101, rd_v);
    txn(1'b1, 1'b0, 32'hBFC0_0004, 32'h0, 4'hF, rd_v);
    chk("merge_word", rd_v, 32'hAA22_CC44);
    txn(1'b1, 1'b0, 32'hBFC0_0004, 32'h0, 4'b0011, rd_v);
    txn(1'b1, 1'b0, 32'hBFC0_0006, 32'h0, 4'hF, rd_v);
    txn(1'b0, 1'b1, 32'hBFC0_0004, 32'hFFFF_FFFF, 4'b0000, rd_v);
    txn(1'b1, 1'b0, 32'hBFC0_0004, 32'h0, 4'hF, rd_v);

    // Unmapped accesses.
    txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF, rd_v);
    chk("unmapped_data", rd_v, 32'hDEAD_BEEF);
    txn(1'b0, 1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF, rd_v);

    // Read and write together: protocol error, memory untouched.
    txn(1'b0, 1'b1, 32'h0000_0010, 32'h5A5A_1234, 4'hF, rd_v);
    txn(1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF, rd_v);
    txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, rd_v);
    chk("conflict_keep", rd_v, 32'h5A5A_1234);

    // Region edges.
    txn(1'b0, 1'b1, 32'hB400_003C, 32'hCAFE_0001, 4'hF, rd_v);
    txn(1'b1, 1'b0, 32'hB400_003C, 32'h0, 4'hF, rd_v);
    txn(1'b1, 1'b0, 32'hB400_0040, 32'h0, 4'hF, rd_v);
    txn(1'b0, 1'b1, 32'h0000_0FFC, 32'hCAFE_0002, 4'hF, rd_v);
    txn(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 4'hF, rd_v);
    txn(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF, rd_v);
    txn(1'b1, 1'b0, 32'hBFBE_0000, 32'h0, 4'hF, rd_v);

    // Reset while a write is waiting: the write must be abandoned.
    txn(1'b0, 1'b1, 32'h0000_0020, 32'h0102_0304, 4'hF, rd_v);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("midrst_wait", 32'(s_wait), 32'd1);
    chk("midrst_err", 32'(s_err), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF, rd_v);
    chk("midrst_keep", rd_v, 32'h0102_0304);

    // Random traffic with LFSR stalls over a fixed word set in every region.
    sel = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 8; j++) begin
        txn(1'b0, 1'b1, BASES[r] + 32'(4 * j * (WORDS[r] / 8)), $urandom, 4'hF, rd_v);
      end
    end
    for (int n = 0; n < 1000; n++) begin
      int          r, j;
      logic [31:0] a;
      logic        is_rd;
      r     = int'($urandom_range(0, 3));
      j     = int'($urandom_range(0, 7));
      a     = BASES[r] + 32'(4 * j * (WORDS[r] / 8));
      is_rd = 1'($urandom_range(0, 1));
      txn(is_rd, !is_rd, a, $urandom, 4'($urandom), rd_v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
